// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one asynchronous SRAM between a camera pixel writer (s0) and a
//   host readout/debug port (s1). Camera writes cannot be stalled, so they
//   land in a 2-entry FIFO that always wins arbitration. The host uses a
//   req/ack handshake for single-word reads and writes. Every SRAM pin and
//   host-side output comes straight from a flop.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   s0_WE/s0_Addr/s0_WD   camera write strobe (active low), address, data
//   s0_overflow           sticky: a camera word was dropped (FIFO full)
//   clr_overflow          synchronous clear of s0_overflow (set wins)
//   s1_req/s1_wr/s1_addr/s1_wdata  host request, held until s1_ack
//   s1_ack/s1_rdata       one-cycle completion pulse, read data
//   mem_CE_n/WE_n/OE_n    SRAM controls, active low
//   mem_A/mem_DQ_o        SRAM address and write data
//   mem_DQ_oe             DQ pad drive enable, active high
//   mem_DQ_i              SRAM read data
module sram_port_arbiter #(
  parameter int AW      = 18,
  parameter int DW      = 32,
  parameter int RD_WAIT = 2     // 1..2 cycles of OE_n low per read
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s0_WE,
  input  logic [AW-1:0] s0_Addr,
  input  logic [DW-1:0] s0_WD,
  output logic          s0_overflow,
  input  logic          clr_overflow,
  input  logic          s1_req,
  input  logic          s1_wr,
  input  logic [AW-1:0] s1_addr,
  input  logic [DW-1:0] s1_wdata,
  output logic          s1_ack,
  output logic [DW-1:0] s1_rdata,
  output logic          mem_CE_n,
  output logic          mem_WE_n,
  output logic          mem_OE_n,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_DQ_o,
  output logic          mem_DQ_oe,
  input  logic [DW-1:0] mem_DQ_i
);

  typedef enum logic [1:0] {IDLE, WR, WR_HOLD, RD} state_e;

  localparam logic [1:0] RD_LAST = 2'(RD_WAIT - 1);

  // Camera FIFO
  logic [AW-1:0] fifo_addr [2];
  logic [DW-1:0] fifo_data [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;
  logic          overflow_q;

  // Access FSM and registered outputs
  state_e        state_q;
  logic          src_s1_q;     // access in flight belongs to the host
  logic [1:0]    rd_cnt_q;
  logic          ce_n_q, we_n_q, oe_n_q, dq_oe_q, ack_q;
  logic [AW-1:0] a_q;
  logic [DW-1:0] dq_o_q, rdata_q;

  logic          push, pop, push_ok, s0_avail, s1_pending;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    push      = ~s0_WE;
    // The head leaves the FIFO in the WR cycle of its own write.
    pop       = (state_q == WR) && !src_s1_q;
    push_ok   = push && ((count_q != 2'd2) || pop);
    // An incoming strobe counts as pending so an idle FSM grants it at once;
    // it is pushed into the head slot on the same edge and popped in WR.
    s0_avail  = (count_q != 2'd0) || push;
    head_addr = s0_Addr;
    head_data = s0_WD;
    if (count_q != 2'd0) begin
      head_addr = fifo_addr[rd_ptr_q];
      head_data = fifo_data[rd_ptr_q];
    end
    // The held request is not re-issued in its own ack cycle, nor in the
    // WR_HOLD cycle of the host write that is just finishing.
    s1_pending = s1_req && !ack_q && !((state_q == WR_HOLD) && src_s1_q);
  end

  // NOTE: FIFO storage has no reset; count and pointers alone define which
  // entries are valid, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_addr[wr_ptr_q] <= s0_Addr;
      fifo_data[wr_ptr_q] <= s0_WD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= ~wr_ptr_q;
      if (pop)     rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (push && !push_ok)  overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      src_s1_q <= 1'b0;
      rd_cnt_q <= 2'd0;
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      a_q      <= '0;
      dq_o_q   <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        WR: begin
          state_q <= WR_HOLD;
          we_n_q  <= 1'b1;
        end
        RD: begin
          if (rd_cnt_q == 2'd0) begin
            state_q <= IDLE;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            rdata_q <= mem_DQ_i;
            ack_q   <= 1'b1;
          end else begin
            rd_cnt_q <= rd_cnt_q - 2'd1;
          end
        end
        default: begin  // IDLE and WR_HOLD: arbitrate for the next access
          if ((state_q == WR_HOLD) && src_s1_q) ack_q <= 1'b1;
          if (s0_avail) begin
            state_q  <= WR;
            src_s1_q <= 1'b0;
            ce_n_q   <= 1'b0;
            we_n_q   <= 1'b0;
            oe_n_q   <= 1'b1;
            dq_oe_q  <= 1'b1;
            a_q      <= head_addr;
            dq_o_q   <= head_data;
          end else if (s1_pending) begin
            src_s1_q <= 1'b1;
            ce_n_q   <= 1'b0;
            a_q      <= s1_addr;
            if (s1_wr) begin
              state_q <= WR;
              we_n_q  <= 1'b0;
              oe_n_q  <= 1'b1;
              dq_oe_q <= 1'b1;
              dq_o_q  <= s1_wdata;
            end else begin
              state_q  <= RD;
              we_n_q   <= 1'b1;
              oe_n_q   <= 1'b0;
              dq_oe_q  <= 1'b0;
              rd_cnt_q <= RD_LAST;
            end
          end else begin
            state_q <= IDLE;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign s0_overflow = overflow_q;
  assign s1_ack      = ack_q;
  assign s1_rdata    = rdata_q;
  assign mem_CE_n    = ce_n_q;
  assign mem_WE_n    = we_n_q;
  assign mem_OE_n    = oe_n_q;
  assign mem_A       = a_q;
  assign mem_DQ_o    = dq_o_q;
  assign mem_DQ_oe   = dq_oe_q;

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single external 18-bit-address, 32-bit-data asynchronous SRAM between two masters.
- Master s0 is the camera pixel writer. It issues one-cycle active-low write strobes, cannot be stalled, and issues at most one strobe every 4 cycles.
- Master s1 is the host readout/debug port. It uses a req/ack handshake for single-word reads and writes.
- The block drives the SRAM pins directly. s0 writes are buffered in a 2-entry FIFO so they are never blocked by an s1 access in flight.

Parameters:
- AW, 18, address width.
- DW, 32, data width.
- RD_WAIT, 2, number of cycles mem_OE_n is held low per read; legal range 1..2. Data is sampled on the last of these cycles.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- s0_WE  in  1  active-low camera write strobe, one cycle per word.
- s0_Addr  in  AW  camera write address, valid when s0_WE=0.
- s0_WD  in  DW  camera write data, valid when s0_WE=0.
- s0_overflow  out  1  sticky flag: a camera write was dropped.
- clr_overflow  in  1  synchronous clear of s0_overflow.
- s1_req  in  1  host request; held with fields stable until s1_ack.
- s1_wr  in  1  1 = write, 0 = read.
- s1_addr  in  AW  host address.
- s1_wdata  in  DW  host write data.
- s1_ack  out  1  one-cycle completion pulse.
- s1_rdata  out  DW  read data; valid in the s1_ack cycle of a read, held until the next read completes.
- mem_CE_n  out  1  SRAM chip enable, active low.
- mem_WE_n  out  1  SRAM write enable, active low.
- mem_OE_n  out  1  SRAM output enable, active low.
- mem_A  out  AW  SRAM address.
- mem_DQ_o  out  DW  SRAM write data.
- mem_DQ_oe  out  1  DQ pad output enable, active high.
- mem_DQ_i  in  DW  SRAM read data.

Behaviour:
- Reset values:
  - mem_CE_n=1, mem_WE_n=1, mem_OE_n=1.
  - mem_A=0, mem_DQ_o=0, mem_DQ_oe=0.
  - s1_ack=0, s1_rdata=0, s0_overflow=0.
  - FIFO empty, state IDLE.
- Reset asserted mid-access aborts the access immediately. SRAM pins go inactive and the FIFO contents are lost.
- All outputs are registered.
- FIFO (2 entries of {addr,data}):
  - A push occurs on any cycle with s0_WE=0.
  - A pop occurs when the FSM grants s0.
  - Simultaneous push and pop is legal; the count is unchanged.
  - Push with count=2 and no pop in the same cycle drops the word and sets s0_overflow.
  - If overflow set and clr_overflow coincide, set wins.
- FSM states:
  - IDLE: outputs inactive.
  - WR: CE_n=0, WE_n=0, DQ_oe=1, mem_A and mem_DQ_o loaded.
  - WR_HOLD: CE_n=0, WE_n=1, DQ_oe=1, address and data unchanged.
  - RD: CE_n=0, OE_n=0, DQ_oe=0, counts RD_WAIT cycles.
- Arbitration is evaluated in IDLE and WR_HOLD, so back-to-back accesses have no idle gap:
  - FIFO non-empty has strict priority: go to WR with the FIFO head.
  - Otherwise, s1_req=1 and s1_ack=0: go to WR if s1_wr=1, to RD if s1_wr=0.
  - Otherwise go to IDLE.
  - s1_req is ignored in the cycle s1_ack=1, so a held request is not re-issued.
- Camera write latency:
  - s0_WE low in cycle N with the FSM in IDLE gives mem_WE_n low in cycle N+1.
  - N+2 is the WR_HOLD cycle.
- Host write: s1_ack pulses in the cycle after WR_HOLD.
- Host read:
  - mem_DQ_i is captured into s1_rdata at the end of the last RD cycle.
  - s1_ack=1 in the following cycle.
  - Read latency from grant is RD_WAIT+1 cycles.
- The worst-case s1 access is 3 cycles and s0 arrives no faster than every 4 cycles, so the FIFO never overflows under legal traffic. Overflow indicates a protocol violation.
- The address is never altered; no wrap handling is required in this block.

Test Plan:
- Reset, then idle 10 cycles:
  - all mem controls stay 1 and mem_DQ_oe=0;
  - s1_ack=0 and s0_overflow=0.
- Single camera write: s0_WE=0 for 1 cycle, addr 0x00010, data 0xA5A5_0001 -> next cycle mem_WE_n=0, mem_A=0x00010, mem_DQ_o=0xA5A5_0001, then one WR_HOLD cycle, then IDLE.
- Host read, RD_WAIT=2: addr 0x3FFFE, mem_DQ_i model returns 0x1234_5678 -> mem_OE_n low 2 cycles, then s1_ack=1 for one cycle with s1_rdata=0x1234_5678.
- Collision: host read granted, and in the following cycle s0_WE=0 (addr 0x00020) ->
  - the read completes undisturbed;
  - the camera write executes immediately after RD ends;
  - memory model holds the data at 0x00020.
- Camera stream of one word every 4 cycles for 1000 words, with continuous host reads ->
  - all 1000 words appear in the memory model in order;
  - s0_overflow stays 0;
  - every host request is acked.
- Violation: 3 camera strobes on consecutive cycles while a host read is in RD ->
  - the third word is dropped and s0_overflow=1;
  - the flag stays set until clr_overflow=1, then reads 0 the next cycle.
